// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings
// (common with the control unit), FSM states and small op-class helpers.
package muldiv_pkg;

    localparam int ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared 2W+1 bit accumulator:
// shift-add multiply or restoring-divide subtract/shift.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = ITER_DEFAULT
) (
    input  logic           is_div_i,
    input  logic [W-1:0]   opnd_i,
    input  logic [2*W:0]   acc_i,
    output logic [2*W:0]   acc_o
);

    logic [W:0]   sum;
    logic [W:0]   rem_sh;
    logic [W+1:0] diff;

    always_comb begin
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        acc_o  = acc_i;
        if (!is_div_i) begin
            // Upper W+1 bits collect partial products; lower W bits hold the
            // remaining multiplier bits and shift out as product bits land.
            sum   = acc_i[2*W:W] + (acc_i[0] ? {1'b0, opnd_i} : '0);
            acc_o = {1'b0, sum, acc_i[W-1:1]};
        end else begin
            // {rem, quo} occupy acc[2W-1:0]; rem is always < divisor so the
            // shifted remainder fits in W+1 bits.
            rem_sh = {acc_i[2*W-1:W], acc_i[W-1]};
            diff   = {1'b0, rem_sh} - {2'b00, opnd_i};
            if (!diff[W+1])
                acc_o = {diff[W:0], acc_i[W-2:0], 1'b1};
            else
                acc_o = {rem_sh, acc_i[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: 32 radix-2 iterations on
// magnitudes, then a sign-fix cycle that loads hi/lo for the HILO write.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic            clk_in,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [ITER-1:0] a,
    input  logic [ITER-1:0] b,
    input  logic            cancel,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [ITER-1:0] hi,
    output logic [ITER-1:0] lo,
    output logic            div_zero
);

    localparam int W     = ITER;
    localparam int CNT_W = $clog2(ITER);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic [W-1:0]      opnd_q, opnd_d;
    logic [2*W:0]      acc_q, acc_d;
    logic [W-1:0]      hi_q, hi_d;
    logic [W-1:0]      lo_q, lo_d;
    logic              div_zero_q, div_zero_d;

    logic [2*W:0]      step_acc;
    logic              in_div, in_sgn;
    logic [W-1:0]      a_mag, b_mag;
    logic [2*W-1:0]    prod;
    logic [W-1:0]      quo, rem;

    assign in_div = md_is_div(op);
    assign in_sgn = md_is_signed(op);
    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is its correct unsigned magnitude.
    assign a_mag  = (in_sgn && a[W-1]) ? (~a + 1'b1) : a;
    assign b_mag  = (in_sgn && b[W-1]) ? (~b + 1'b1) : b;

    muldiv_step #(.W(W)) u_step (
        .is_div_i (is_div_q),
        .opnd_i   (opnd_q),
        .acc_i    (acc_q),
        .acc_o    (step_acc)
    );

    assign prod = neg_q ? (~acc_q[2*W-1:0] + 1'b1) : acc_q[2*W-1:0];
    assign quo  = neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    assign rem  = rneg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    is_div_d   = in_div;
                    neg_d      = in_sgn & (a[W-1] ^ b[W-1]);
                    rneg_d     = in_sgn & a[W-1];
                    dz_d       = in_div & (b == '0);
                    opnd_d     = in_div ? b_mag : a_mag;
                    acc_d      = {{(W+1){1'b0}}, (in_div ? a_mag : b_mag)};
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    // Divide-by-zero bypasses the iterations but still passes
                    // through SIGN so hi/lo load on the edge entering DONE.
                    if (in_div && (b == '0)) begin
                        acc_d   = {{(W+1){1'b0}}, a};
                        state_d = ST_SIGN;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER-1))
                        state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    if (dz_q) begin
                        hi_d       = acc_q[W-1:0];
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*W-1:W];
                        lo_d = prod[W-1:0];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign stall    = ((state_q == ST_IDLE) && start && !cancel) ||
                      (state_q == ST_CALC) || (state_q == ST_SIGN);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, random ops
// against an arithmetic reference, plus cancel/reset corner sequences.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk_in, reset_n, start, cancel;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        stall, busy, done, div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_seq dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference from plain 64-bit arithmetic; SV / and % truncate toward zero
    // and give the remainder the dividend's sign.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
        longint      sx, sy, q, r;
        logic [63:0] p, ux, uy;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'h0, x};
        uy  = {32'h0, y};
        rdz = 1'b0;
        p   = '0;
        if (o[1] && y == 32'h0) begin
            rdz = 1'b1;
            p   = {x, 32'hFFFF_FFFF};
        end else begin
            case (o)
                MD_MULT:  p = sx * sy;
                MD_MULTU: p = ux * uy;
                MD_DIV: begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
                default:  p = {32'(ux % uy), 32'(ux / uy)};
            endcase
        end
        rhi = p[63:32];
        rlo = p[31:0];
    endfunction

    // Issue one op and return at the negedge where done is visible; cyc is
    // the number of edges after the start edge until DONE was entered.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output bit stall_ok);
        @(negedge clk_in);
        start = 1'b1; op = o; a = x; b = y;
        #1 stall_ok = (stall === 1'b1);
        @(posedge clk_in);
        cyc = 0;
        @(negedge clk_in);
        start = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk_in);
            cyc++;
            @(negedge clk_in);
        end
        if (stall !== 1'b0) stall_ok = 1'b0;
    endtask

    task automatic op_and_check(input string name, input logic [1:0] o, input logic [31:0] x,
                                input logic [31:0] y);
        logic [31:0] ehi, elo;
        logic        edz;
        int          cyc;
        bit          sok;
        model(o, x, y, ehi, elo, edz);
        run_op(o, x, y, cyc, sok);
        chk({name, ".hilo"}, {hi, lo}, {ehi, elo});
        chk({name, ".dz"}, 64'(div_zero), 64'(edz));
        chk({name, ".cyc"}, 64'(cyc), (o[1] && y == 0) ? 64'd1 : 64'd33);
        if (!sok) chk({name, ".stall"}, 64'(sok), 64'd1);
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        int          cyc;
        bit          sok;
        bit          saw_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[3] = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 33};
        vecs[5] = '{MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0, 33};
        vecs[6] = '{MD_MULTU, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, 33};

        reset_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
        #1;
        chk("reset.outs", {58'h0, busy, done, stall, div_zero, 2'b00}, 64'h0);
        chk("reset.hilo", {hi, lo}, 64'h0);
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, sok);
            chk($sformatf("vec%0d.hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            chk($sformatf("vec%0d.dz", i), 64'(div_zero), 64'(vecs[i].dz));
            chk($sformatf("vec%0d.cyc", i), 64'(cyc), 64'(vecs[i].cyc));
            chk($sformatf("vec%0d.stall", i), 64'(sok), 64'd1);
            @(posedge clk_in);
            @(negedge clk_in);
            chk($sformatf("vec%0d.idle", i), {62'h0, done, busy}, 64'h0);
        end

        // Cancel a MULT after 10 iterations: no done, previous hi/lo retained.
        @(negedge clk_in);
        start = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd6;
        @(posedge clk_in);
        @(negedge clk_in);
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (done) saw_done = 1'b1;
        end
        chk("cancel.busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        cancel = 1'b0;
        chk("cancel.busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk_in);
            @(negedge clk_in);
        end
        chk("cancel.nodone", 64'(saw_done), 64'd0);
        chk("cancel.hilo", {hi, lo}, {32'd0, 32'd12});

        // start together with cancel in IDLE is ignored.
        start = 1'b1; cancel = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd3;
        #1 chk("startcancel.stall", 64'(stall), 64'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        start = 1'b0; cancel = 1'b0;
        chk("startcancel.busy", 64'(busy), 64'd0);
        chk("startcancel.hilo", {hi, lo}, {32'd0, 32'd12});

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       begin ra = 32'h8000_0000; rb = $urandom; end
                default: rb = $urandom;
            endcase
            op_and_check($sformatf("rand%0d", i), ro, ra, rb);
        end

        // Divide by zero first so div_zero is set, then reset mid-CALC.
        op_and_check("predz", MD_DIV, 32'h1234_5678, 32'h0);
        @(negedge clk_in);
        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk_in);
        @(negedge clk_in);
        start = 1'b0;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset.outs", {58'h0, busy, done, stall, div_zero, 2'b00}, 64'h0);
        chk("midreset.hilo", {hi, lo}, 64'h0);
        @(negedge clk_in);
        reset_n = 1'b1;
        op_and_check("postreset", MD_DIVU, 32'd7, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
